// File: rtl/approx_mult_err_acc.sv
// approx_mult_err_acc: streaming error-distance statistics accumulator for 8x8 approximate multipliers
module approx_mult_err_acc #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [15:0]      R,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] over_cnt,
  output logic [15:0]      err_max,
  output logic [SUM_W-1:0] err_sum
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] n_lat;
  logic s1_valid;
  logic [7:0] s1_a, s1_b;
  logic [15:0] s1_r, exact, ed;
  logic [SUM_W:0] sum_ext;
  logic launch, accept, last;
  assign in_ready = state == RUN;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  always_comb begin
    launch = start && (state == IDLE || state == DONE);
    accept = in_valid && in_ready;
    last = accept && (sample_cnt + CNT_W'(1) == n_lat);
    exact = {8'd0, s1_a} * {8'd0, s1_b};
    ed = exact >= s1_r ? exact - s1_r : s1_r - exact;
    sum_ext = {1'b0, err_sum} + (SUM_W+1)'(ed);
    state_nx = launch ? (n_samples == '0 ? DONE : RUN) :
               (state == RUN && last) ? DRAIN :
               (state == DRAIN && s1_valid) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_lat <= '0;
      s1_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_r <= '0;
      sample_cnt <= '0;
      err_cnt <= '0;
      over_cnt <= '0;
      err_max <= '0;
      err_sum <= '0;
    end else begin
      state <= state_nx;
      s1_valid <= accept;
      if (accept) begin
        s1_a <= A;
        s1_b <= B;
        s1_r <= R;
      end
      if (launch) begin
        n_lat <= n_samples;
        sample_cnt <= '0;
        err_cnt <= '0;
        over_cnt <= '0;
        err_max <= '0;
        err_sum <= '0;
      end else begin
        if (accept) sample_cnt <= sample_cnt + CNT_W'(1);
        if (s1_valid) begin
          err_cnt <= err_cnt + CNT_W'(ed != 16'd0);
          over_cnt <= over_cnt + CNT_W'(s1_r > exact);
          err_max <= ed > err_max ? ed : err_max;
          err_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_approx_mult_err_acc.sv
// tb_approx_mult_err_acc: randomized and directed checks against a plain-arithmetic statistics model
module tb_approx_mult_err_acc;
  logic clk = 0, rst = 0, start = 0, in_valid = 0;
  logic [15:0] n_samples = 0;
  logic [7:0] A = 0, B = 0;
  logic [15:0] R = 0;
  logic in_ready, busy, done;
  logic [15:0] sample_cnt, err_cnt, over_cnt, err_max;
  logic [15:0] err_sum;
  int vectors = 0, miscompares = 0;
  int qa[$], qb[$], qr[$], qg[$];
  logic [79:0] got, exp_s;
  approx_mult_err_acc #(.CNT_W(16), .SUM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .R(R),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .over_cnt(over_cnt), .err_max(err_max), .err_sum(err_sum)
  );
  always #5 clk = ~clk;
  assign got = {sample_cnt, err_cnt, over_cnt, err_max, err_sum};
  function automatic logic [79:0] model();
    int sc = 0, ec = 0, oc = 0, mx = 0, sm = 0;
    foreach (qa[i]) begin
      int p, e;
      p = qa[i] * qb[i];
      e = p >= qr[i] ? p - qr[i] : qr[i] - p;
      sc++;
      if (e != 0) ec++;
      if (qr[i] > p) oc++;
      if (e > mx) mx = e;
      sm = (sm + e > 65535) ? 65535 : sm + e;
    end
    return {16'(sc), 16'(ec), 16'(oc), 16'(mx), 16'(sm)};
  endfunction
  task automatic clear_q();
    qa.delete(); qb.delete(); qr.delete(); qg.delete();
  endtask
  task automatic push(input int a, input int b, input int r, input int g);
    qa.push_back(a); qb.push_back(b); qr.push_back(r); qg.push_back(g);
  endtask
  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1; n_samples = 16'(n);
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic feed(input int from);
    for (int i = from; i < qa.size(); i++) begin
      repeat (qg[i]) begin @(posedge clk); #1; end
      in_valid = 1; A = 8'(qa[i]); B = 8'(qb[i]); R = 16'(qr[i]);
      @(posedge clk); #1;
      in_valid = 0;
    end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    vectors++;
    if ({in_ready, busy, done, got} !== 83'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=0", {in_ready, busy, done, got});
    end
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({in_ready, sample_cnt} !== 17'd0) begin
        miscompares++;
        $display("FAIL idle_no_accept got=%h want=0", {in_ready, sample_cnt});
      end
    end
    in_valid = 0;
  endtask
  task automatic test_exact();
    clear_q();
    push(15, 15, 225, 0); push(0, 200, 0, 0); push(8, 8, 64, 0);
    do_start(3);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL exact_ready got=%b want=1", in_ready);
    end
    feed(0);
    vectors++;
    if ({in_ready, busy, done} !== 3'b010) begin
      miscompares++;
      $display("FAIL exact_drain got=%b want=010", {in_ready, busy, done});
    end
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, got} !== {2'b01, 16'd3, 64'd0}) begin
      miscompares++;
      $display("FAIL exact_stats got=%h want=%h", {busy, done, got}, {2'b01, 16'd3, 64'd0});
    end
  endtask
  task automatic test_mix();
    clear_q();
    push(255, 255, 65535, 0); push(16, 16, 200, 0);
    do_start(2);
    feed(0);
    @(posedge clk); #1;
    vectors++;
    if ({done, got} !== {1'b1, 16'd2, 16'd2, 16'd1, 16'd510, 16'd566}) begin
      miscompares++;
      $display("FAIL mix_stats got=%h want=%h", {done, got}, {1'b1, 16'd2, 16'd2, 16'd1, 16'd510, 16'd566});
    end
  endtask
  task automatic test_stall();
    clear_q();
    push(255, 255, 0, 0); push(255, 255, 0, 2); push(255, 255, 0, 5);
    do_start(3);
    feed(0);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_early_done got=%b want=0", done);
    end
    @(posedge clk); #1;
    vectors++;
    if ({done, got} !== {1'b1, 16'd3, 16'd3, 16'd0, 16'd65025, 16'd65535}) begin
      miscompares++;
      $display("FAIL stall_sat got=%h want=%h", {done, got}, {1'b1, 16'd3, 16'd3, 16'd0, 16'd65025, 16'd65535});
    end
  endtask
  task automatic test_zero_and_ignored_start();
    do_start(0);
    vectors++;
    if ({busy, done, sample_cnt} !== {2'b01, 16'd0}) begin
      miscompares++;
      $display("FAIL zero_len got=%h want=%h", {busy, done, sample_cnt}, {2'b01, 16'd0});
    end
    clear_q();
    for (int i = 0; i < 4; i++) push(i + 3, 7, 0, 0);
    do_start(4);
    qa = qa[0:1]; qb = qb[0:1]; qr = qr[0:1]; qg = qg[0:1];
    feed(0);
    start = 1; n_samples = 16'd1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 2; i++) push(i + 5, 7, 0, 0);
    feed(2);
    vectors++;
    if ({busy, done, sample_cnt} !== {2'b10, 16'd4}) begin
      miscompares++;
      $display("FAIL ignored_start_drain got=%h want=%h", {busy, done, sample_cnt}, {2'b10, 16'd4});
    end
    @(posedge clk); #1;
    exp_s = model();
    vectors++;
    if ({done, got} !== {1'b1, exp_s}) begin
      miscompares++;
      $display("FAIL ignored_start_stats got=%h want=%h", {done, got}, {1'b1, exp_s});
    end
  endtask
  task automatic test_reset_mid();
    clear_q();
    push(200, 100, 5, 0); push(9, 9, 90, 0);
    do_start(2);
    feed(0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    vectors++;
    if ({in_ready, busy, done, got} !== 83'd0) begin
      miscompares++;
      $display("FAIL reset_mid got=%h want=0", {in_ready, busy, done, got});
    end
    @(posedge clk); #1;
    vectors++;
    if (got !== 80'd0) begin
      miscompares++;
      $display("FAIL reset_mid_flush got=%h want=0", got);
    end
  endtask
  task automatic test_random();
    for (int run = 0; run < 8; run++) begin
      int n;
      n = $urandom_range(1, 12);
      clear_q();
      for (int i = 0; i < n; i++) begin
        int a, b, p, r;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        p = a * b;
        case ($urandom_range(0, 2))
          0: r = p;
          1: r = p + $urandom_range(0, 64) - 32;
          default: r = $urandom_range(0, 65535);
        endcase
        r = r < 0 ? 0 : (r > 65535 ? 65535 : r);
        push(a, b, r, $urandom_range(0, 3));
      end
      do_start(n);
      feed(0);
      vectors++;
      if ({in_ready, busy, done} !== 3'b010) begin
        miscompares++;
        $display("FAIL rand_drain run=%0d got=%b want=010", run, {in_ready, busy, done});
      end
      @(posedge clk); #1;
      exp_s = model();
      vectors++;
      if ({busy, done, got} !== {2'b01, exp_s}) begin
        miscompares++;
        $display("FAIL rand_stats run=%0d got=%h want=%h", run, {busy, done, got}, {2'b01, exp_s});
      end
      in_valid = 1; A = 8'hff; B = 8'hff; R = 16'd0;
      repeat (3) @(posedge clk);
      #1 in_valid = 0;
      vectors++;
      if ({done, got} !== {1'b1, exp_s}) begin
        miscompares++;
        $display("FAIL rand_hold run=%0d got=%h want=%h", run, {done, got}, {1'b1, exp_s});
      end
    end
  endtask
  initial begin
    test_reset();
    test_exact();
    test_mix();
    test_stall();
    test_zero_and_ignored_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
